sample_stream_source: RTL and testbench
=======================================

SAMPLE_STREAM_SOURCE -- requirements
Module: sample_stream_source

Interface
REQ-001 Parameter: DATA_WIDTH, 8, stream byte width.
REQ-002 Parameter: LEN_WIDTH, 8, burst length and counter width.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  burst request, sampled every cycle.
REQ-006 Port: burst_len  input  LEN_WIDTH  number of bytes to send, sampled with start.
REQ-007 Port: seed  input  DATA_WIDTH  first byte value, sampled with start.
REQ-008 Port: busy  output  1  high from accepted start until end of DONE.
REQ-009 Port: done  output  1  one-cycle pulse at burst end.
REQ-010 Port: stream_out_valid  output  1  byte available downstream.
REQ-011 Port: stream_out_data  output  DATA_WIDTH  byte payload.
REQ-012 Port: stream_out_ready  input  1  downstream accepts (driven by receiver's stream_in_ready).
REQ-013 Port: sent_count  output  LEN_WIDTH  bytes transferred in current/last burst.

Function
REQ-014 FSM states IDLE, RUN, DONE; transfer = stream_out_valid && stream_out_ready on a rising edge.
REQ-015 IDLE + start + burst_len!=0: latch seed/burst_len, clear sent_count, go RUN; next cycle valid=1, data=seed.
REQ-016 IDLE + start + burst_len==0: go DONE directly, no valid asserted, sent_count cleared to 0.
REQ-017 start in RUN or DONE is ignored; no queuing.
REQ-018 Once asserted, valid and data held stable until transfer (no withdraw, no change).
REQ-019 Each transfer: sent_count+1; next data = previous+1 modulo 2^DATA_WIDTH (0xFF -> 0x00).
REQ-020 Back-to-back: ready held high gives one transfer per cycle, no bubbles.
REQ-021 Transfer of byte burst_len: valid low next cycle, go DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-022 busy = (state != IDLE); done only in DONE; sent_count holds final value in IDLE.
REQ-023 burst_len 2^LEN_WIDTH-1 is the maximum; sent_count never wraps.

Reset
REQ-024 reset_n low: state IDLE, stream_out_valid 0, stream_out_data 0, busy 0, done 0, sent_count 0 immediately, independent of clk.
REQ-025 Reset mid-burst aborts: no done pulse, valid drops asynchronously; first start after release behaves as REQ-015.

Configuration
REQ-026 Macro SAMPLE_STREAM_SOURCE_CHECK_EN defined: adds ports chk_valid input 1, chk_data input DATA_WIDTH, chk_errors output 8 (return-path checker).
REQ-027 With macro: expected value loaded with seed on accepted start; each chk_valid cycle compares chk_data, increments expected; mismatch increments chk_errors, saturating at 255; chk_errors cleared by reset and accepted start.
REQ-028 Without macro: chk_* ports and checker logic absent; remaining behaviour identical.

Structure
REQ-029 Package sample_stream_pkg holds the state enum typedef and default width constants.
REQ-030 Checker in sub-module sample_stream_checker, instantiated only under SAMPLE_STREAM_SOURCE_CHECK_EN.

Verification
REQ-031 start, burst_len=4, seed=0x10, ready=1 -> data 0x10,0x11,0x12,0x13 on 4 consecutive cycles; done pulse 1 cycle after last; sent_count=4.
REQ-032 seed=0xFE, burst_len=3, ready=1 -> 0xFE,0xFF,0x00.
REQ-033 burst_len=3, ready low 5 cycles after first valid -> valid/data stable 0x?? at seed throughout stall; total 3 transfers.
REQ-034 burst_len=0 -> done pulse 1 cycle after start, valid never high, sent_count=0; start during RUN -> ignored.
REQ-035 reset_n low after 2 of 6 transfers -> valid 0 at once, no done; new burst after release starts at new seed.
REQ-036 CHECK_EN, receiver loopback seed=0x20 len 4, one corrupted return byte -> chk_errors=1; clean rerun -> 0.

Source files
------------

// File: rtl/sample_stream_pkg.sv
// Shared types and default widths for the sample stream source and its checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sample_stream_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_LEN_WIDTH  = 8;
   localparam int CHK_ERR_WIDTH  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sample_stream_checker.sv
// Return-path checker: compares looped-back bytes against an incrementing expectation.
// Latency: error count updates on the clock edge that samples a mismatching chk_valid beat.
// Backpressure: none; every chk_valid cycle is consumed, error count saturates at its maximum.
module sample_stream_checker
   import sample_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     load,
   input  logic [DATA_WIDTH-1:0]    seed,
   input  logic                     chk_valid,
   input  logic [DATA_WIDTH-1:0]    chk_data,
   output logic [CHK_ERR_WIDTH-1:0] chk_errors
);

   localparam logic [DATA_WIDTH-1:0]    DATA_ONE = 1;
   localparam logic [CHK_ERR_WIDTH-1:0] ERR_ONE  = 1;
   localparam logic [CHK_ERR_WIDTH-1:0] ERR_MAX  = '1;

   logic [DATA_WIDTH-1:0]    exp_q, exp_d;
   logic [CHK_ERR_WIDTH-1:0] err_q, err_d;

   // A new burst reloads the expectation and clears the count; otherwise each beat is scored.
   always_comb begin
      exp_d = exp_q;
      err_d = err_q;
      if (load) begin
         exp_d = seed;
         err_d = '0;
      end else if (chk_valid) begin
         exp_d = exp_q + DATA_ONE;
         if ((chk_data != exp_q) && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_ONE;
         end
      end
   end

   // Checker state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_q <= '0;
         err_q <= '0;
      end else begin
         exp_q <= exp_d;
         err_q <= err_d;
      end
   end

   assign chk_errors = err_q;

endmodule

// File: rtl/sample_stream_source.sv
// Burst source: emits burst_len incrementing bytes from seed; optional return checker under SAMPLE_STREAM_SOURCE_CHECK_EN.
// Latency: first byte valid the cycle after an accepted start; done pulses the cycle after the last transfer.
// Backpressure: valid/data hold stable while stream_out_ready is low; one byte per cycle when ready stays high.
module sample_stream_source
   import sample_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [LEN_WIDTH-1:0]     burst_len,
   input  logic [DATA_WIDTH-1:0]    seed,
   output logic                     busy,
   output logic                     done,
   output logic                     stream_out_valid,
   output logic [DATA_WIDTH-1:0]    stream_out_data,
   input  logic                     stream_out_ready,
`ifdef SAMPLE_STREAM_SOURCE_CHECK_EN
   input  logic                     chk_valid,
   input  logic [DATA_WIDTH-1:0]    chk_data,
   output logic [CHK_ERR_WIDTH-1:0] chk_errors,
`endif
   output logic [LEN_WIDTH-1:0]     sent_count
);

   localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

   state_e                  state_q, state_d;
   logic                    valid_q, valid_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0]    cnt_inc;

   // The count can never pass len_q, so this increment cannot wrap within a burst.
   assign cnt_inc = cnt_q + LEN_ONE;

   // Next-state and datapath: accept start only in IDLE, advance on each transfer, close on the last one.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      data_d  = data_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d = '0;
               if (burst_len != '0) begin
                  len_d   = burst_len;
                  data_d  = seed;
                  valid_d = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (valid_q && stream_out_ready) begin
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) begin
                  valid_d = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  data_d = data_q + DATA_ONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset aborts any burst immediately, including the valid output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         data_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy             = (state_q != ST_IDLE);
   assign done             = (state_q == ST_DONE);
   assign stream_out_valid = valid_q;
   assign stream_out_data  = data_q;
   assign sent_count       = cnt_q;

`ifdef SAMPLE_STREAM_SOURCE_CHECK_EN
   logic chk_load;

   // Any accepted start, including a zero-length one, rearms the checker.
   assign chk_load = (state_q == ST_IDLE) && start;

   sample_stream_checker #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_checker (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (chk_load),
      .seed       (seed),
      .chk_valid  (chk_valid),
      .chk_data   (chk_data),
      .chk_errors (chk_errors)
   );
`endif

endmodule

// File: tb/tb_sample_stream_source.sv
// Directed bench for sample_stream_source; the checker scenario is built when SAMPLE_STREAM_SOURCE_CHECK_EN is defined.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: stream_out_ready is driven directly by the bench.
module tb_sample_stream_source;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] burst_len;
   logic [7:0] seed;
   logic       busy;
   logic       done;
   logic       stream_out_valid;
   logic [7:0] stream_out_data;
   logic       stream_out_ready;
   logic [7:0] sent_count;

   int vec_cnt = 0;
   int err_cnt = 0;

`ifdef SAMPLE_STREAM_SOURCE_CHECK_EN
   logic       chk_valid;
   logic [7:0] chk_data;
   logic [7:0] chk_errors;
   logic [7:0] corrupt_mask;

   assign chk_valid = stream_out_valid & stream_out_ready;
   assign chk_data  = stream_out_data ^ corrupt_mask;
`endif

   sample_stream_source #(
      .DATA_WIDTH (8),
      .LEN_WIDTH  (8)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .burst_len        (burst_len),
      .seed             (seed),
      .busy             (busy),
      .done             (done),
      .stream_out_valid (stream_out_valid),
      .stream_out_data  (stream_out_data),
      .stream_out_ready (stream_out_ready),
`ifdef SAMPLE_STREAM_SOURCE_CHECK_EN
      .chk_valid        (chk_valid),
      .chk_data         (chk_data),
      .chk_errors       (chk_errors),
`endif
      .sent_count       (sent_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start = 1'b0;
      burst_len = 8'd0;
      seed = 8'd0;
      stream_out_ready = 1'b0;
`ifdef SAMPLE_STREAM_SOURCE_CHECK_EN
      corrupt_mask = 8'd0;
`endif
      #3;
      vec_cnt++;
      if ({busy, done, stream_out_valid} !== 3'b000) begin
         err_cnt++;
         $display("FAIL reset_ctrl: busy/done/valid=%b expected 000", {busy, done, stream_out_valid});
      end
      vec_cnt++;
      if (stream_out_data !== 8'h00 || sent_count !== 8'h00) begin
         err_cnt++;
         $display("FAIL reset_data: data=%h count=%h expected 00 00", stream_out_data, sent_count);
      end
`ifdef SAMPLE_STREAM_SOURCE_CHECK_EN
      vec_cnt++;
      if (chk_errors !== 8'h00) begin
         err_cnt++;
         $display("FAIL reset_chk: chk_errors=%h expected 00", chk_errors);
      end
`endif
      step();
      step();
      reset_n = 1'b1;
      step();
      vec_cnt++;
      if (busy !== 1'b0 || stream_out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_release: busy=%b valid=%b expected 0 0", busy, stream_out_valid);
      end
   endtask

   // seed 0x10, length 4, ready held high: four back-to-back bytes then done.
   task automatic test_back_to_back();
      start = 1'b1;
      burst_len = 8'd4;
      seed = 8'h10;
      stream_out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vec_cnt++;
         if (stream_out_valid !== 1'b1 || stream_out_data !== 8'h10 + 8'(i) || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_byte%0d: valid=%b data=%h busy=%b expected 1 %h 1",
                     i, stream_out_valid, stream_out_data, busy, 8'h10 + 8'(i));
         end
         step();
      end
      vec_cnt++;
      if (done !== 1'b1 || stream_out_valid !== 1'b0 || sent_count !== 8'd4) begin
         err_cnt++;
         $display("FAIL b2b_done: done=%b valid=%b count=%0d expected 1 0 4", done, stream_out_valid, sent_count);
      end
      step();
      vec_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || sent_count !== 8'd4) begin
         err_cnt++;
         $display("FAIL b2b_idle: done=%b busy=%b count=%0d expected 0 0 4", done, busy, sent_count);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_b [3];
      exp_b = '{8'hFE, 8'hFF, 8'h00};
      start = 1'b1;
      burst_len = 8'd3;
      seed = 8'hFE;
      stream_out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vec_cnt++;
         if (stream_out_valid !== 1'b1 || stream_out_data !== exp_b[i]) begin
            err_cnt++;
            $display("FAIL wrap_byte%0d: valid=%b data=%h expected 1 %h", i, stream_out_valid, stream_out_data, exp_b[i]);
         end
         step();
      end
      vec_cnt++;
      if (done !== 1'b1 || sent_count !== 8'd3) begin
         err_cnt++;
         $display("FAIL wrap_done: done=%b count=%0d expected 1 3", done, sent_count);
      end
      step();
   endtask

   task automatic test_stall();
      int stall_bad;
      stall_bad = 0;
      start = 1'b1;
      burst_len = 8'd3;
      seed = 8'h40;
      stream_out_ready = 1'b0;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (stream_out_valid !== 1'b1 || stream_out_data !== 8'h40 || sent_count !== 8'd0) stall_bad++;
         step();
      end
      vec_cnt++;
      if (stall_bad != 0) begin
         err_cnt++;
         $display("FAIL stall_hold: %0d stalled cycles unstable, expected 0 (valid=%b data=%h)",
                  stall_bad, stream_out_valid, stream_out_data);
      end
      stream_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vec_cnt++;
         if (stream_out_valid !== 1'b1 || stream_out_data !== 8'h40 + 8'(i)) begin
            err_cnt++;
            $display("FAIL stall_byte%0d: valid=%b data=%h expected 1 %h", i, stream_out_valid, stream_out_data, 8'h40 + 8'(i));
         end
         step();
      end
      vec_cnt++;
      if (done !== 1'b1 || sent_count !== 8'd3) begin
         err_cnt++;
         $display("FAIL stall_done: done=%b count=%0d expected 1 3", done, sent_count);
      end
      step();
   endtask

   task automatic test_zero_len();
      start = 1'b1;
      burst_len = 8'd0;
      seed = 8'h77;
      stream_out_ready = 1'b1;
      step();
      start = 1'b0;
      vec_cnt++;
      if (done !== 1'b1 || busy !== 1'b1 || stream_out_valid !== 1'b0 || sent_count !== 8'd0) begin
         err_cnt++;
         $display("FAIL zero_done: done=%b busy=%b valid=%b count=%0d expected 1 1 0 0",
                  done, busy, stream_out_valid, sent_count);
      end
      step();
      vec_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || stream_out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL zero_idle: done=%b busy=%b valid=%b expected 0 0 0", done, busy, stream_out_valid);
      end
   endtask

   // start left high through RUN and DONE with different seed/length must not disturb the burst.
   task automatic test_start_ignored();
      start = 1'b1;
      burst_len = 8'd3;
      seed = 8'h80;
      stream_out_ready = 1'b1;
      step();
      seed = 8'h00;
      burst_len = 8'd9;
      for (int i = 0; i < 3; i++) begin
         vec_cnt++;
         if (stream_out_data !== 8'h80 + 8'(i) || stream_out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL ign_byte%0d: valid=%b data=%h expected 1 %h", i, stream_out_valid, stream_out_data, 8'h80 + 8'(i));
         end
         step();
      end
      vec_cnt++;
      if (done !== 1'b1 || sent_count !== 8'd3) begin
         err_cnt++;
         $display("FAIL ign_done: done=%b count=%0d expected 1 3", done, sent_count);
      end
      start = 1'b0;
      step();
      vec_cnt++;
      if (busy !== 1'b0 || sent_count !== 8'd3 || stream_out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL ign_idle: busy=%b count=%0d valid=%b expected 0 3 0", busy, sent_count, stream_out_valid);
      end
   endtask

   task automatic test_reset_mid();
      int done_seen;
      done_seen = 0;
      start = 1'b1;
      burst_len = 8'd6;
      seed = 8'h30;
      stream_out_ready = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      vec_cnt++;
      if (sent_count !== 8'd2 || stream_out_data !== 8'h32) begin
         err_cnt++;
         $display("FAIL mid_pre: count=%0d data=%h expected 2 32", sent_count, stream_out_data);
      end
      #2;
      reset_n = 1'b0;
      #1;
      vec_cnt++;
      if (stream_out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          sent_count !== 8'd0 || stream_out_data !== 8'h00) begin
         err_cnt++;
         $display("FAIL mid_async: valid=%b busy=%b done=%b count=%0d data=%h expected 0 0 0 0 00",
                  stream_out_valid, busy, done, sent_count, stream_out_data);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         if (done !== 1'b0) done_seen++;
      end
      reset_n = 1'b1;
      step();
      if (done !== 1'b0) done_seen++;
      vec_cnt++;
      if (done_seen != 0) begin
         err_cnt++;
         $display("FAIL mid_nodone: done seen %0d times, expected 0", done_seen);
      end
      start = 1'b1;
      burst_len = 8'd2;
      seed = 8'h55;
      step();
      start = 1'b0;
      vec_cnt++;
      if (stream_out_valid !== 1'b1 || stream_out_data !== 8'h55 || sent_count !== 8'd0) begin
         err_cnt++;
         $display("FAIL mid_restart: valid=%b data=%h count=%0d expected 1 55 0", stream_out_valid, stream_out_data, sent_count);
      end
      step();
      step();
      vec_cnt++;
      if (done !== 1'b1 || sent_count !== 8'd2) begin
         err_cnt++;
         $display("FAIL mid_restart_done: done=%b count=%0d expected 1 2", done, sent_count);
      end
      step();
   endtask

   // Maximum length 255 from seed 0: bytes 0x00..0xFE, count stops at 255 without wrapping.
   task automatic test_max_len();
      int xfers;
      int bad_data;
      int cyc;
      logic [7:0] exp_d;
      xfers = 0;
      bad_data = 0;
      cyc = 0;
      exp_d = 8'h00;
      start = 1'b1;
      burst_len = 8'd255;
      seed = 8'h00;
      stream_out_ready = 1'b1;
      step();
      start = 1'b0;
      while (done !== 1'b1 && cyc < 400) begin
         if (stream_out_valid === 1'b1) begin
            if (stream_out_data !== exp_d) bad_data++;
            exp_d = exp_d + 8'd1;
            xfers++;
         end
         step();
         cyc++;
      end
      vec_cnt++;
      if (done !== 1'b1) begin
         err_cnt++;
         $display("FAIL max_timeout: done=%b after %0d cycles, expected 1", done, cyc);
      end
      vec_cnt++;
      if (xfers != 255 || bad_data != 0 || sent_count !== 8'd255) begin
         err_cnt++;
         $display("FAIL max_len: xfers=%0d bad=%0d count=%0d expected 255 0 255", xfers, bad_data, sent_count);
      end
      step();
   endtask

`ifdef SAMPLE_STREAM_SOURCE_CHECK_EN
   task automatic test_checker();
      for (int run = 0; run < 2; run++) begin
         start = 1'b1;
         burst_len = 8'd4;
         seed = 8'h20;
         stream_out_ready = 1'b1;
         step();
         start = 1'b0;
         vec_cnt++;
         if (chk_errors !== 8'd0) begin
            err_cnt++;
            $display("FAIL chk_clear%0d: chk_errors=%0d expected 0", run, chk_errors);
         end
         for (int i = 0; i < 4; i++) begin
            corrupt_mask = (run == 0 && i == 1) ? 8'h04 : 8'h00;
            step();
         end
         corrupt_mask = 8'h00;
         vec_cnt++;
         if (chk_errors !== ((run == 0) ? 8'd1 : 8'd0) || done !== 1'b1) begin
            err_cnt++;
            $display("FAIL chk_run%0d: chk_errors=%0d done=%b expected %0d 1",
                     run, chk_errors, done, (run == 0) ? 1 : 0);
         end
         step();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_wrap();
      test_stall();
      test_zero_len();
      test_start_ignored();
      test_reset_mid();
      test_max_len();
`ifdef SAMPLE_STREAM_SOURCE_CHECK_EN
      test_checker();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
